// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
// The frame constants describe the downstream 9600-baud transmitter at 50 MHz.
package uart_pkg;

    localparam int unsigned CLK_FREQ     = 50_000_000;
    localparam int unsigned BAUD         = 9600;
    localparam int unsigned CLKS_PER_BIT = 5208;
    localparam int unsigned FRAME_CLKS   = 52083;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } tx_state_e;

    // Fallback for tools without $clog2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear.
// Storage is not reset; only pointers and count are.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CntOne  = (AW+1)'(1);
    localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == CntFull);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
            if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
            if (do_wr && !do_rd) count_d = count_q + CntOne;
            if (do_rd && !do_wr) count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter one byte at a time, waiting for
// tx_done (or a timeout) before launching the next byte.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   timeout_err
);

    tx_state_e   state_q, state_d;
    logic        tx_en_q;
    logic [7:0]  tx_data_q;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_err_q;

    logic        push, launch, timed_out, timeout_hit;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_rd_data;

    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (launch),
        .rd_data (fifo_rd_data),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Counter starts at 0 on launch, so TIMEOUT-1 is reached TIMEOUT edges later.
    assign timed_out = (TIMEOUT != 0) && (tmo_cnt_q == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!fifo_empty && !flush) state_d = StWait;
            StWait: if (tx_done || timed_out)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        launch      = (state_q == StIdle) && !fifo_empty && !flush;
        busy        = (state_q == StWait);
        timeout_hit = (state_q == StWait) && !tx_done && timed_out;
        tmo_cnt_d   = tmo_cnt_q;
        if (launch)    tmo_cnt_d = '0;
        else if (busy) tmo_cnt_d = tmo_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_en_q   <= launch;
            tmo_cnt_q <= tmo_cnt_d;
            if (launch)      tx_data_q     <= fifo_rd_data;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end

    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed launch orders and timings.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       flush = 1'b0;
    logic       tx_done = 1'b0;
    logic       in_ready, tx_en, busy, timeout_err;
    logic [7:0] tx_data;
    logic [4:0] count;

    uart_tx_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .count       (count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue, one in-flight slot, absolute launch time.
    logic [7:0] m_q[$];
    bit         m_inflight = 0;
    int         m_launch_edge = 0;
    logic [7:0] m_tx_data = 8'h00;
    bit         m_tx_en = 0;
    bit         m_err = 0;
    bit         m_push_ok, m_launch;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_q.delete();
            m_inflight = 0;
            m_tx_data  = 8'h00;
            m_tx_en    = 0;
            m_err      = 0;
        end else begin
            m_push_ok = in_valid && !flush && (m_q.size() < DEPTH);
            m_launch  = !m_inflight && (m_q.size() != 0) && !flush;
            m_tx_en   = m_launch;
            if (m_inflight) begin
                if (tx_done) m_inflight = 0;
                else if (cyc - m_launch_edge == TIMEOUT) begin
                    m_err      = 1;
                    m_inflight = 0;
                end
            end else if (m_launch) begin
                m_tx_data     = m_q.pop_front();
                m_inflight    = 1;
                m_launch_edge = cyc;
            end
            if (flush) m_q.delete();
            if (m_push_ok) m_q.push_back(in_data);
        end
    end

    // Launch log of the DUT, for the directed literal checks.
    logic [7:0] dut_sent[$];
    int         dut_lcyc[$];
    int         dut_max = 0;
    int         err_cyc = -1;

    initial forever begin
        @(negedge clk);
        check("tx_en",       32'(tx_en),       32'(m_tx_en));
        check("tx_data",     32'(tx_data),     32'(m_tx_data));
        check("count",       32'(count),       32'(m_q.size()));
        check("busy",        32'(busy),        32'(m_inflight));
        check("in_ready",    32'(in_ready),    32'((m_q.size() < DEPTH) && !flush));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        if (tx_en === 1'b1) begin
            dut_sent.push_back(tx_data);
            dut_lcyc.push_back(cyc);
        end
        if (int'(count) > dut_max) dut_max = int'(count);
        if (timeout_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end

    // tx_done stub: pulse done_delay edges after a launch; 0 means never answer.
    int done_delay = 30;
    int resp_cnt   = 0;

    initial forever begin
        @(posedge clk);
        #2;
        tx_done = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) tx_done = 1'b1;
            end
            if (tx_en === 1'b1 && done_delay > 0) resp_cnt = done_delay;
        end
    end

    task automatic push(input logic [7:0] b, output int acc_cyc);
        bit ok;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 5000);
        in_valid = 1'b0;
        check("push_accept", 32'(ok), 32'd1);
        acc_cyc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_inflight) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(m_q.size() == 0 && !m_inflight), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_log();
        dut_sent.delete();
        dut_lcyc.delete();
        dut_max = 0;
    endtask

    int acc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte: launch one edge after the accepting edge.
        clear_log();
        push(8'h41, acc);
        repeat (3) @(posedge clk);
        #1;
        check("single_launches", 32'(dut_sent.size()), 32'd1);
        if (dut_sent.size() > 0) begin
            check("single_data", 32'(dut_sent[0]), 32'h41);
            check("single_latency", 32'(dut_lcyc[0] - acc), 32'd1);
        end
        check("single_busy", 32'(busy), 32'd1);
        drain();

        // Burst of 17 from reset: first launches, 16 remain and the queue is full.
        pulse_rst();
        clear_log();
        for (int i = 0; i < 17; i++) push(8'(i), acc);
        check("burst_count_full", 32'(count), 32'd16);
        check("burst_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("burst_stall_count", 32'(count), 32'd16);
        drain();
        check("burst_launches", 32'(dut_sent.size()), 32'd17);
        for (int i = 0; i < 17 && i < dut_sent.size(); i++)
            check("burst_order", 32'(dut_sent[i]), 32'(i));
        for (int i = 1; i < 17 && i < dut_lcyc.size(); i++)
            check("burst_gap", 32'(dut_lcyc[i] - dut_lcyc[i-1]), 32'd32);
        check("burst_max_count", 32'(dut_max), 32'd16);

        // Wrap-around: 40 bytes paced every 10 clocks, pointers wrap twice.
        clear_log();
        for (int i = 0; i < 40; i++) begin
            push(8'h80 + 8'(i), acc);
            repeat (9) @(posedge clk);
            #1;
        end
        drain();
        check("wrap_launches", 32'(dut_sent.size()), 32'd40);
        for (int i = 0; i < 40 && i < dut_sent.size(); i++)
            check("wrap_order", 32'(dut_sent[i]), 32'h80 + 32'(i));
        check("wrap_max_le_depth", 32'(dut_max <= 16), 32'd1);

        // Flush while 0x11 is in flight, with a simultaneous push of 0x44.
        clear_log();
        push(8'h11, acc);
        push(8'h22, acc);
        push(8'h33, acc);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h44;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        drain();
        check("flush_launches", 32'(dut_sent.size()), 32'd1);
        if (dut_sent.size() > 0) check("flush_data", 32'(dut_sent[0]), 32'h11);

        // Timeout: no tx_done ever; error rises 100 edges after the launch.
        done_delay = 0;
        clear_log();
        err_cyc = -1;
        push(8'h5A, acc);
        push(8'h5B, acc);
        drain();
        check("tmo_launches", 32'(dut_sent.size()), 32'd2);
        if (dut_sent.size() == 2) begin
            check("tmo_first", 32'(dut_sent[0]), 32'h5A);
            check("tmo_second", 32'(dut_sent[1]), 32'h5B);
            check("tmo_err_time", 32'(err_cyc - dut_lcyc[0]), 32'd100);
            check("tmo_next_launch", 32'(dut_lcyc[1] - dut_lcyc[0]), 32'd101);
        end
        repeat (20) @(posedge clk);
        #1;
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        done_delay = 30;

        // Reset in WAIT with three bytes queued.
        clear_log();
        push(8'hA1, acc);
        push(8'hA2, acc);
        push(8'hA3, acc);
        push(8'hA4, acc);
        check("rst_pre_count", 32'(count), 32'd3);
        pulse_rst();
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        repeat (100) @(posedge clk);
        #1;
        check("rst_no_relaunch", 32'(dut_sent.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
